// File: rtl/vending_machine_pkg.sv
// Shared types and constants for the vending-machine controller.
// Optional feature macro: VENDING_MACHINE_CANCEL_EN (enables the cancel input).
package vending_machine_pkg;

  localparam int ITEM_W    = 2;
  localparam int ITEM_OH_W = 4;
  localparam int MONEY_W   = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'b000,
    ST_RECEIVE  = 3'b010,
    ST_DISPENSE = 3'b011,
    ST_REFUND   = 3'b100
  } state_e;

  localparam logic [2:0] COIN_5  = 3'b001;
  localparam logic [2:0] COIN_10 = 3'b010;
  localparam logic [2:0] COIN_20 = 3'b100;

  localparam logic [MONEY_W-1:0] PRICE [ITEM_OH_W] = '{8'd3, 8'd12, 8'd20, 8'd45};

  function automatic logic [MONEY_W-1:0] coin_value(input logic [2:0] code);
    logic [MONEY_W-1:0] val_s;
    case (code)
      COIN_5:  val_s = 8'd5;
      COIN_10: val_s = 8'd10;
      COIN_20: val_s = 8'd20;
      default: val_s = 8'd0;
    endcase
    return val_s;
  endfunction

  function automatic logic [MONEY_W-1:0] price_of(input logic [ITEM_W-1:0] item);
    return PRICE[item];
  endfunction

  function automatic logic [ITEM_OH_W-1:0] item_onehot(input logic [ITEM_W-1:0] item);
    return 4'b0001 << item;
  endfunction

endpackage

// File: rtl/vending_machine_fsm.sv
// Transaction FSM: state register, saturating credit accumulator and item latch.
// Exposes the decision for the coming edge so the top can register the result outputs.
module vending_machine_fsm
  import vending_machine_pkg::*;
#(
  parameter int MAX_MONEY = 60
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               done_money,
  input  logic               cancel,
  input  logic               continue_buy,
  input  logic [ITEM_W-1:0]  item_in,
  input  logic [2:0]         money,
  output logic               dispense_next,
  output logic               refund_next,
  output logic [MONEY_W-1:0] change_next,
  output logic [ITEM_W-1:0]  item
);

  localparam logic [MONEY_W:0] MAX_MONEY_C = 9'(MAX_MONEY);

  state_e               state_r;
  logic [MONEY_W-1:0]   credit_r;
  logic [ITEM_W-1:0]    item_r;
  logic [MONEY_W:0]     sum_s;
  logic [MONEY_W-1:0]   credit_next_s;
  logic [MONEY_W-1:0]   price_s;
  logic                 cancel_s;
  logic                 end_trans_s;

`ifdef VENDING_MACHINE_CANCEL_EN
  assign cancel_s = cancel;
`else
  logic unused_cancel_s;
  assign unused_cancel_s = cancel;
  assign cancel_s        = 1'b0;
`endif

  assign end_trans_s = (state_r == ST_DISPENSE) || (state_r == ST_REFUND);
  assign item        = item_r;
  assign price_s     = price_of(item_r);

  // Saturating credit update; the 9-bit sum cannot wrap before the clamp.
  always_comb begin
    sum_s = {1'b0, credit_r} + {1'b0, coin_value(money)};
    if (sum_s > MAX_MONEY_C) begin
      credit_next_s = MAX_MONEY_C[MONEY_W-1:0];
    end else begin
      credit_next_s = sum_s[MONEY_W-1:0];
    end
  end

  // Purchase decision taken in RECEIVE; cancel outranks done_money.
  always_comb begin
    dispense_next = 1'b0;
    refund_next   = 1'b0;
    change_next   = 8'd0;
    if (state_r == ST_RECEIVE) begin
      if (cancel_s) begin
        refund_next = 1'b1;
        change_next = credit_next_s;
      end else if (done_money && (credit_next_s >= price_s)) begin
        dispense_next = 1'b1;
        change_next   = credit_next_s - price_s;
      end else if (done_money) begin
        refund_next = 1'b1;
        change_next = credit_next_s;
      end else begin
        change_next = 8'd0;
      end
    end else begin
      change_next = 8'd0;
    end
  end

  // State, credit and item latch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= ST_IDLE;
      credit_r <= 8'd0;
      item_r   <= 2'd0;
    end else if (end_trans_s) begin
      credit_r <= 8'd0;
      if (continue_buy) begin
        item_r  <= item_in;
        state_r <= ST_RECEIVE;
      end else begin
        state_r <= ST_IDLE;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            item_r   <= item_in;
            credit_r <= 8'd0;
            state_r  <= ST_RECEIVE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RECEIVE: begin
          credit_r <= credit_next_s;
          if (refund_next) begin
            state_r <= ST_REFUND;
          end else if (dispense_next) begin
            state_r <= ST_DISPENSE;
          end else begin
            state_r <= ST_RECEIVE;
          end
        end
        default: begin
          credit_r <= 8'd0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/vending_machine.sv
// Vending-machine controller top: FSM instance plus registered result outputs.
// Optional feature macro: VENDING_MACHINE_CANCEL_EN (enables the cancel input).
module vending_machine
  import vending_machine_pkg::*;
#(
  parameter int MAX_MONEY = 60
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 done_money,
  input  logic                 cancel,
  input  logic                 continue_buy,
  input  logic [ITEM_W-1:0]    item_in,
  input  logic [2:0]           money,
  output logic                 done,
  output logic [ITEM_OH_W-1:0] item_out,
  output logic [MONEY_W-1:0]   change
);

  logic               dispense_next_s;
  logic               refund_next_s;
  logic [MONEY_W-1:0] change_next_s;
  logic [ITEM_W-1:0]  item_s;

  vending_machine_fsm #(.MAX_MONEY(MAX_MONEY)) U1 (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .done_money   (done_money),
    .cancel       (cancel),
    .continue_buy (continue_buy),
    .item_in      (item_in),
    .money        (money),
    .dispense_next(dispense_next_s),
    .refund_next  (refund_next_s),
    .change_next  (change_next_s),
    .item         (item_s)
  );

  // Result registers load on the same edge the FSM enters DISPENSE/REFUND.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done     <= 1'b0;
      item_out <= 4'b0000;
      change   <= 8'd0;
    end else begin
      done     <= dispense_next_s;
      item_out <= dispense_next_s ? item_onehot(item_s) : 4'b0000;
      change   <= (dispense_next_s || refund_next_s) ? change_next_s : 8'd0;
    end
  end

endmodule

// File: tb/tb_vending_machine.sv
// Self-checking bench for vending_machine: directed vector table, corner sequences
// and randomized traffic against a transaction-level reference model.
module tb_vending_machine;

  localparam int MAXM = 60;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0, done_money = 1'b0, cancel = 1'b0, continue_buy = 1'b0;
  logic [1:0] item_in = 2'd0;
  logic [2:0] money = 3'd0;
  logic       done;
  logic [3:0] item_out;
  logic [7:0] change;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef VENDING_MACHINE_CANCEL_EN
  localparam bit CANCEL_ON = 1'b1;
`else
  localparam bit CANCEL_ON = 1'b0;
`endif

  vending_machine #(.MAX_MONEY(MAXM)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .done_money(done_money),
    .cancel(cancel), .continue_buy(continue_buy), .item_in(item_in),
    .money(money), .done(done), .item_out(item_out), .change(change)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic st, dm, cn, cb;
    logic [1:0] it;
    logic [2:0] mn;
    logic ed;
    logic [3:0] eo;
    logic [7:0] ec;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic st, dm, cn, cb, input logic [1:0] it,
                              input logic [2:0] mn, input logic ed,
                              input logic [3:0] eo, input logic [7:0] ec);
    vec_t v;
    v.st = st; v.dm = dm; v.cn = cn; v.cb = cb; v.it = it; v.mn = mn;
    v.ed = ed; v.eo = eo; v.ec = ec;
    return v;
  endfunction

  task automatic drive(input logic st, dm, cn, cb, input logic [1:0] it, input logic [2:0] mn);
    @(negedge clk);
    start = st; done_money = dm; cancel = cn; continue_buy = cb; item_in = it; money = mn;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    start = 1'b0; done_money = 1'b0; cancel = 1'b0; continue_buy = 1'b0; money = 3'd0;
    reset_n = 1'b0;
    #12;
    reset_n = 1'b1;
  endtask

  // Reference model: a transaction is either idle, collecting coins, or showing a result.
  int m_phase;   // 0 idle, 1 collecting, 2 result shown
  int m_credit, m_item;

  function automatic int price(input int i);
    int p[4] = '{3, 12, 20, 45};
    return p[i];
  endfunction

  function automatic int coin(input logic [2:0] c);
    if (c == 3'b001) return 5;
    if (c == 3'b010) return 10;
    if (c == 3'b100) return 20;
    return 0;
  endfunction

  task automatic model_step(input logic st, dm, cn, cb, input int it, input logic [2:0] mn,
                            output int ed, output int eo, output int ec);
    int c;
    ed = 0; eo = 0; ec = 0;
    if (m_phase == 2) begin
      m_phase = cb ? 1 : 0;
      if (cb) begin m_item = it; m_credit = 0; end
    end else if (m_phase == 1) begin
      c = m_credit + coin(mn);
      if (c > MAXM) c = MAXM;
      m_credit = c;
      if (CANCEL_ON && cn) begin
        ec = c; m_phase = 2;
      end else if (dm) begin
        if (c >= price(m_item)) begin
          ed = 1; eo = 1 << m_item; ec = c - price(m_item);
        end else begin
          ec = c;
        end
        m_phase = 2;
      end
    end else if (st) begin
      m_phase = 1; m_item = it; m_credit = 0;
    end
  endtask

  initial begin
    int ed, eo, ec;
    // Directed table: one row per clock, expectations are the outputs after that edge.
    tbl.push_back(mk(1,0,0,0, 2'd1, 3'b000, 0, 4'b0000, 8'd0));
    tbl.push_back(mk(0,1,0,0, 2'd0, 3'b100, 1, 4'b0010, 8'd8));
    tbl.push_back(mk(0,0,0,0, 2'd0, 3'b000, 0, 4'b0000, 8'd0));
    tbl.push_back(mk(1,0,0,0, 2'd2, 3'b000, 0, 4'b0000, 8'd0));
    tbl.push_back(mk(0,0,0,0, 2'd0, 3'b010, 0, 4'b0000, 8'd0));
    tbl.push_back(mk(0,0,0,0, 2'd0, 3'b011, 0, 4'b0000, 8'd0));
    tbl.push_back(mk(0,1,0,0, 2'd0, 3'b000, 0, 4'b0000, 8'd10));
    tbl.push_back(mk(0,0,0,0, 2'd0, 3'b000, 0, 4'b0000, 8'd0));
    tbl.push_back(mk(1,0,0,0, 2'd3, 3'b000, 0, 4'b0000, 8'd0));
    tbl.push_back(mk(0,0,0,0, 2'd0, 3'b100, 0, 4'b0000, 8'd0));
    tbl.push_back(mk(0,0,0,0, 2'd0, 3'b100, 0, 4'b0000, 8'd0));
    tbl.push_back(mk(0,1,0,0, 2'd0, 3'b001, 1, 4'b1000, 8'd0));
    tbl.push_back(mk(0,0,0,0, 2'd0, 3'b000, 0, 4'b0000, 8'd0));
    tbl.push_back(mk(1,0,0,0, 2'd3, 3'b000, 0, 4'b0000, 8'd0));
    tbl.push_back(mk(0,0,0,0, 2'd0, 3'b100, 0, 4'b0000, 8'd0));
    tbl.push_back(mk(0,0,0,0, 2'd0, 3'b100, 0, 4'b0000, 8'd0));
    tbl.push_back(mk(0,0,0,0, 2'd0, 3'b100, 0, 4'b0000, 8'd0));
    tbl.push_back(mk(0,1,0,0, 2'd0, 3'b100, 1, 4'b1000, 8'd15));  // saturated at 60
    tbl.push_back(mk(0,0,0,0, 2'd0, 3'b000, 0, 4'b0000, 8'd0));
    tbl.push_back(mk(1,0,0,0, 2'd0, 3'b000, 0, 4'b0000, 8'd0));
    tbl.push_back(mk(0,1,0,0, 2'd0, 3'b001, 1, 4'b0001, 8'd2));
    tbl.push_back(mk(0,0,0,1, 2'd2, 3'b000, 0, 4'b0000, 8'd0));
    tbl.push_back(mk(0,1,0,0, 2'd0, 3'b100, 1, 4'b0100, 8'd0));
    tbl.push_back(mk(0,0,0,0, 2'd0, 3'b000, 0, 4'b0000, 8'd0));
    tbl.push_back(mk(1,0,0,0, 2'd1, 3'b000, 0, 4'b0000, 8'd0));
    tbl.push_back(mk(1,0,0,0, 2'd0, 3'b001, 0, 4'b0000, 8'd0));  // start ignored mid-transaction
    if (CANCEL_ON) begin
      tbl.push_back(mk(0,0,1,0, 2'd0, 3'b010, 0, 4'b0000, 8'd15));
      tbl.push_back(mk(0,1,0,0, 2'd0, 3'b000, 0, 4'b0000, 8'd0));
    end else begin
      tbl.push_back(mk(0,0,1,0, 2'd0, 3'b010, 0, 4'b0000, 8'd0));
      tbl.push_back(mk(0,1,0,0, 2'd0, 3'b000, 1, 4'b0010, 8'd3));
    end
    tbl.push_back(mk(0,0,0,0, 2'd0, 3'b000, 0, 4'b0000, 8'd0));

    // Reset state
    #3;
    chk("async_reset_done", done, 0);
    reset_n = 1'b0;
    #12;
    reset_n = 1'b1;
    #1;
    chk("reset_done", done, 0);
    chk("reset_item_out", item_out, 0);
    chk("reset_change", change, 0);
    chk("reset_state", dut.U1.state_r, 3'b000);

    foreach (tbl[i]) begin
      drive(tbl[i].st, tbl[i].dm, tbl[i].cn, tbl[i].cb, tbl[i].it, tbl[i].mn);
      chk($sformatf("vec%0d_done", i), done, tbl[i].ed);
      chk($sformatf("vec%0d_item_out", i), item_out, tbl[i].eo);
      chk($sformatf("vec%0d_change", i), change, tbl[i].ec);
      if (i == 21) begin
        chk("contbuy_state", dut.U1.state_r, 3'b010);
        chk("contbuy_credit", dut.U1.credit_r, 0);
      end
      if (i == 26 && !CANCEL_ON) chk("nocancel_state", dut.U1.state_r, 3'b010);
    end

    // Reset mid-RECEIVE: no refund emitted afterwards.
    drive(1,0,0,0, 2'd2, 3'b000);
    drive(0,0,0,0, 2'd0, 3'b010);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrx_state", dut.U1.state_r, 3'b000);
    chk("midrx_change", change, 0);
    #10;
    reset_n = 1'b1;
    drive(0,1,0,0, 2'd0, 3'b000);
    chk("midrx_no_refund", change, 0);
    chk("midrx_idle", dut.U1.state_r, 3'b000);

    // Reset while a result is showing: outputs clear immediately.
    drive(1,0,0,0, 2'd0, 3'b000);
    drive(0,1,0,0, 2'd0, 3'b100);
    chk("pre_reset_done", done, 1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("reset_clears_done", done, 0);
    chk("reset_clears_item", item_out, 0);
    chk("reset_clears_change", change, 0);
    #10;
    reset_n = 1'b1;

    // Randomized traffic against the reference model.
    do_reset();
    m_phase = 0; m_credit = 0; m_item = 0;
    for (int k = 0; k < 1500; k++) begin
      logic st, dm, cn, cb;
      logic [1:0] it;
      logic [2:0] mn;
      st = ($urandom_range(0, 9) < 3);
      dm = ($urandom_range(0, 9) < 2);
      cn = ($urandom_range(0, 9) < 1);
      cb = ($urandom_range(0, 9) < 4);
      it = 2'($urandom_range(0, 3));
      mn = 3'($urandom_range(0, 7));
      drive(st, dm, cn, cb, it, mn);
      model_step(st, dm, cn, cb, int'(it), mn, ed, eo, ec);
      chk($sformatf("rnd%0d_done", k), done, ed);
      chk($sformatf("rnd%0d_item_out", k), item_out, eo);
      chk($sformatf("rnd%0d_change", k), change, ec);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
